// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: load/store request and response channels between the core and data memory
// master = initiator (core memory stage), slave = responder (data memory)
// req*: valid/ready request carrying write flag, byte address, funct3 and right-aligned store data
// resp*: valid/ready response carrying extended load data and an error flag
interface data_memory_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddress;
  logic [2:0]  reqFunct3;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respReadData;
  logic        respError;
  modport master (
    output reqValid, reqWrite, reqAddress, reqFunct3, reqWriteData, respReady,
    input  reqReady, respValid, respReadData, respError
  );
  modport slave (
    input  reqValid, reqWrite, reqAddress, reqFunct3, reqWriteData, respReady,
    output reqReady, respValid, respReadData, respError
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding RV32I data memory with wait states and error responses
// CLK   : clock, all state changes on the rising edge
// RESET : synchronous active-high reset (memory contents are kept)
// bus   : slave side of the request/response channels
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input logic CLK,
  input logic RESET,
  data_memory_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_write, r_err;
  logic [AW+1:0] r_addr;
  logic [2:0] r_funct3;
  logic [31:0] r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic w_accept, w_bad_f3, w_misaligned, w_range, w_err, w_commit;
  logic [AW-1:0] w_idx;
  logic [4:0] w_shift;
  logic [31:0] w_lane, w_load, w_wshift;
  logic [3:0] w_be;
  assign bus.reqReady = r_state == IDLE && !RESET;
  assign bus.respValid = r_state == RESPOND;
  assign bus.respReadData = r_rdata;
  assign bus.respError = r_err;
  assign w_accept = bus.reqValid && bus.reqReady;
  assign w_bad_f3 = bus.reqWrite ? bus.reqFunct3 > 3'd2 : bus.reqFunct3 == 3'd3 || bus.reqFunct3[2:1] == 2'b11;
  assign w_misaligned = (bus.reqFunct3[1:0] == 2'd1 && bus.reqAddress[0]) ||
                        (bus.reqFunct3[1:0] == 2'd2 && bus.reqAddress[1:0] != 2'd0);
  assign w_range = {2'b00, bus.reqAddress[31:2]} >= 32'(DEPTH_WORDS);
  assign w_err = w_bad_f3 || w_misaligned || w_range;
  assign w_commit = r_state == WAIT && r_cnt == 4'd0;
  assign w_idx = r_addr[AW+1:2];
  assign w_shift = {r_addr[1:0], 3'b000};
  // the addressed lane is moved to bit 0, then truncated and extended; funct3[2] selects zero-extension
  assign w_lane = r_mem[w_idx] >> w_shift;
  assign w_load = r_funct3[1:0] == 2'd0 ? {{24{w_lane[7] & ~r_funct3[2]}}, w_lane[7:0]} :
                  r_funct3[1:0] == 2'd1 ? {{16{w_lane[15] & ~r_funct3[2]}}, w_lane[15:0]} : w_lane;
  assign w_wshift = r_wdata << w_shift;
  assign w_be = r_funct3[1:0] == 2'd0 ? 4'b0001 << r_addr[1:0] :
                r_funct3[1:0] == 2'd1 ? 4'b0011 << r_addr[1:0] : 4'b1111;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = w_err ? RESPOND : WAIT;
    else if (w_commit) w_next = RESPOND;
    else if (r_state == RESPOND && bus.respReady) w_next = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_rdata <= 32'd0;
      r_err <= 1'b0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_funct3 <= 3'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= bus.reqWrite;
        r_addr <= bus.reqAddress[AW+1:0];
        r_funct3 <= bus.reqFunct3;
        r_wdata <= bus.reqWriteData;
        r_cnt <= 4'(WAIT_STATES);
        r_err <= w_err;
        r_rdata <= 32'd0;
      end else if (w_commit) begin
        r_rdata <= r_write ? 32'd0 : w_load;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
  // array has no reset so a store committed before a reset survives it
  always_ff @(posedge CLK) begin
    if (!RESET && w_commit && r_write)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wshift[8*i +: 8];
  end
endmodule
